// File: rtl/pb_pkg.sv
// Shared types and constants for the pushbutton event generator.
package pb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } pb_state_e;

    localparam logic PB_RELEASED = 1'b1;
    localparam logic PB_PRESSED  = 1'b0;

    localparam int unsigned HOLD_CLKS_DEFAULT   = 25000000;
    localparam int unsigned REPEAT_CLKS_DEFAULT = 5000000;

    localparam logic [7:0] REP_MAX = 8'd255;

    function automatic logic [7:0] rep_sat_inc(input logic [7:0] val);
        return (val == REP_MAX) ? val : val + 8'd1;
    endfunction

endpackage

// File: rtl/pb_sync.sv
// Two-flop synchroniser for the button level; both flops reset to the released level.
module pb_sync
    import pb_pkg::*;
(
    input  logic in_clk,
    input  logic in_rst_n,
    input  logic pb_raw,
    output logic pb_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            meta_q <= PB_RELEASED;
            sync_q <= PB_RELEASED;
        end else begin
            meta_q <= pb_raw;
            sync_q <= meta_q;
        end
    end

    assign pb_sync = sync_q;

endmodule

// File: rtl/pb_event_gen.sv
// Turns a debounced active-low button level into press/release/auto-repeat events.
// Define PB_EVENT_SYNC_EN to pass pb_level through a 2-flop synchroniser first.
module pb_event_gen
    import pb_pkg::*;
#(
    parameter int unsigned HOLD_CLKS   = HOLD_CLKS_DEFAULT,
    parameter int unsigned REPEAT_CLKS = REPEAT_CLKS_DEFAULT,
    parameter int unsigned CNT_W       = 25
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       pb_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       move_pulse,
    output logic       held,
    output logic [7:0] rep_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CLKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLKS - 1);

    logic pb_s;

`ifdef PB_EVENT_SYNC_EN
    pb_sync u_pb_sync (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .pb_raw   (pb_level),
        .pb_sync  (pb_s)
    );
`else
    assign pb_s = pb_level;
`endif

    pb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             move_q, move_d;
    logic             held_q, held_d;
    logic [7:0]       rep_q, rep_d;
    logic             fall, rise;

    assign fall = (prev_q == PB_RELEASED) && (pb_s == PB_PRESSED);
    assign rise = (prev_q == PB_PRESSED) && (pb_s == PB_RELEASED);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        move_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    press_d = 1'b1;
                    move_d  = 1'b1;
                    rep_d   = 8'd1;
                    cnt_d   = '0;
                    state_d = StDelay;
                end
            end
            StDelay: begin
                // Release outranks a coincident threshold match.
                if (rise) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    state_d   = StIdle;
                end else if (cnt_q == HOLD_LAST) begin
                    move_d  = 1'b1;
                    rep_d   = rep_sat_inc(rep_q);
                    cnt_d   = '0;
                    held_d  = 1'b1;
                    state_d = StRepeat;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StRepeat: begin
                if (rise) begin
                    release_d = 1'b1;
                    held_d    = 1'b0;
                    state_d   = StIdle;
                end else if (cnt_q == REPEAT_LAST) begin
                    move_d = 1'b1;
                    rep_d  = rep_sat_inc(rep_q);
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                held_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            prev_q    <= PB_RELEASED;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            move_q    <= 1'b0;
            held_q    <= 1'b0;
            rep_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= pb_s;
            press_q   <= press_d;
            release_q <= release_d;
            move_q    <= move_d;
            held_q    <= held_d;
            rep_q     <= rep_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign move_pulse    = move_q;
    assign held          = held_q;
    assign rep_cnt       = rep_q;

endmodule

// File: tb/tb_pb_event_gen.sv
// Directed bench for pb_event_gen with HOLD_CLKS = 10, REPEAT_CLKS = 4.
module tb_pb_event_gen;

    localparam int unsigned HOLD  = 10;
    localparam int unsigned REP   = 4;
    localparam int unsigned CNT_W = 8;
`ifdef PB_EVENT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       in_clk   = 1'b0;
    logic       in_rst_n = 1'b0;
    logic       pb_level = 1'b1;
    logic       press_pulse;
    logic       release_pulse;
    logic       move_pulse;
    logic       held;
    logic [7:0] rep_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int rep_exp = 0;

    pb_event_gen #(
        .HOLD_CLKS   (HOLD),
        .REPEAT_CLKS (REP),
        .CNT_W       (CNT_W)
    ) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .pb_level      (pb_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .move_pulse    (move_pulse),
        .held          (held),
        .rep_cnt       (rep_cnt)
    );

    always #5 in_clk = ~in_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {press_pulse, release_pulse, move_pulse, held, rep_cnt}, 32'd0);
    endtask

    // Press at offset 0, release driven at offset hold; check every cycle up to total.
    task automatic run_press(input string tag, input int hold, input int total);
        bit exp_move;
        int nmoves;
        pb_level = 1'b0;
        nmoves   = 0;
        for (int c = 1; c <= total; c++) begin
            tick();
            exp_move = (c < hold + LAT) &&
                       ((c == LAT) || ((c >= LAT + HOLD) && ((c - LAT - HOLD) % REP == 0)));
            if (exp_move) begin
                nmoves++;
                rep_exp = (nmoves > 255) ? 255 : nmoves;
            end
            check_eq($sformatf("%s press c=%0d", tag, c), press_pulse, (c == LAT));
            check_eq($sformatf("%s move c=%0d", tag, c), move_pulse, exp_move);
            check_eq($sformatf("%s release c=%0d", tag, c), release_pulse, (c == hold + LAT));
            check_eq($sformatf("%s held c=%0d", tag, c), held,
                     (c >= LAT + HOLD) && (c < hold + LAT));
            check_eq($sformatf("%s rep_cnt c=%0d", tag, c), rep_cnt, rep_exp);
            if (c == hold) pb_level = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_rst_n = 1'b0;
        pb_level = 1'b1;
        repeat (3) tick();
        check_all_zero("in_reset");

        in_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_all_zero($sformatf("idle c=%0d", c));
        end

        run_press("short", 3, 3 + LAT + 3);
        check_eq("short rep_cnt kept", rep_cnt, 32'd1);
        repeat (4) tick();
        check_eq("short rep_cnt idle", rep_cnt, 32'd1);

        run_press("hold30", 30, 30 + LAT + 3);
        check_eq("hold30 rep_cnt", rep_cnt, 32'd6);
        repeat (4) tick();

        run_press("tie", HOLD, HOLD + LAT + 3);
        check_eq("tie rep_cnt", rep_cnt, 32'd1);
        repeat (4) tick();

        run_press("sat", 1100, 1100 + LAT + 3);
        check_eq("sat rep_cnt", rep_cnt, 32'd255);
        repeat (4) tick();

        // Reset in the middle of auto-repeat, button still held across deassert.
        pb_level = 1'b0;
        repeat (LAT + HOLD + 5) tick();
        check_eq("mid held", held, 32'd1);
        in_rst_n = 1'b0;
        #1;
        check_all_zero("async reset");
        rep_exp = 0;
        repeat (2) tick();
        check_all_zero("reset hold");
        in_rst_n = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            check_eq($sformatf("rearm press c=%0d", c), press_pulse, (c == LAT));
            check_eq($sformatf("rearm move c=%0d", c), move_pulse, (c == LAT));
            check_eq($sformatf("rearm rep_cnt c=%0d", c), rep_cnt, (c >= LAT) ? 1 : 0);
            check_eq($sformatf("rearm held c=%0d", c), held, 32'd0);
        end
        pb_level = 1'b1;
        repeat (LAT) tick();
        check_eq("rearm release", release_pulse, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pb_event_gen.md
Name: pb_event_gen

Overview:
- Consumer-side partner of the pushbutton debouncer.
- Takes the clean, active-low debounced button level and turns it into single-cycle control events:
  - press pulse
  - release pulse
  - auto-repeating move pulse
  - long-hold indicator
  - saturating repeat count
- One instance per button, sitting between the debouncer and the paddle/menu logic of the game.

Parameters:
- HOLD_CLKS, 25000000, clocks a press must be held before auto-repeat starts (500 ms at 50 MHz); must be >= 2.
- REPEAT_CLKS, 5000000, clocks between auto-repeat move pulses (100 ms at 50 MHz); must be >= 2.
- CNT_W, 25, counter width; must satisfy 2^CNT_W > max(HOLD_CLKS, REPEAT_CLKS).

Ports:
- in_clk, input, 1, system clock; all logic on its rising edge.
- in_rst_n, input, 1, asynchronous active-low reset.
- pb_level, input, 1, debounced button level; 1 = not pressed, 0 = pressed.
- press_pulse, output, 1, one-cycle pulse on each new press.
- release_pulse, output, 1, one-cycle pulse on each release.
- move_pulse, output, 1, one-cycle pulse on press, at hold threshold, then every REPEAT_CLKS.
- held, output, 1, high while in auto-repeat state.
- rep_cnt, output, 8, number of move pulses since the current press (includes the press), saturates at 255.

Behaviour:
- Reset (in_rst_n = 0, asynchronous): state = IDLE, cnt = 0, prev = 1 (not pressed), all outputs = 0, rep_cnt = 0.
- Definitions:
  - pressed = ~pb_s, where pb_s is pb_level, or its synchronised copy when the optional feature is on.
  - fall = prev & ~pb_s.
  - rise = ~prev & pb_s.
  - prev <= pb_s every cycle.
- All outputs are registered:
  - A pulse appears in the cycle after the edge/threshold is sampled.
  - Latency is 1 clock from pb_s change to press_pulse/release_pulse.
- Pulse outputs default to 0 every cycle unless asserted below.
- State machine:
  - IDLE:
    - On fall: press_pulse = 1, move_pulse = 1, rep_cnt = 1, cnt = 0, go to DELAY.
    - Otherwise stay in IDLE.
  - DELAY:
    - On rise: release_pulse = 1, go to IDLE (highest priority).
    - Else if cnt == HOLD_CLKS-1: move_pulse = 1, rep_cnt += 1 (saturating), cnt = 0, go to REPEAT, held = 1.
    - Else cnt += 1.
  - REPEAT:
    - On rise: release_pulse = 1, held = 0, go to IDLE.
    - Else if cnt == REPEAT_CLKS-1: move_pulse = 1, rep_cnt += 1 (saturating), cnt = 0.
    - Else cnt += 1.
- Boundary rules:
  - Release on the same cycle as a threshold match: release wins, no move_pulse.
  - rep_cnt holds its value after release until the next press reloads it to 1.
  - rep_cnt sticks at 255; move_pulse continues.
  - Reset asserted mid-hold returns immediately to reset values.
    - After reset deassert with the button still held: prev = 1, so the first sampled 0 produces a fresh press.
  - pb_s stuck at 0 from reset is treated as one press.
  - cnt never exceeds max(HOLD_CLKS, REPEAT_CLKS)-1; no wrap occurs.

Optional Feature:
- Macro: PB_EVENT_SYNC_EN.
- Defined:
  - pb_level passes through a 2-flop synchroniser (both flops reset to 1) before edge detection.
  - Input-to-pulse latency becomes 3 clocks.
  - Allows a raw or asynchronous source.
- Undefined:
  - pb_level is used directly.
  - Latency is 1 clock.
  - Source must already be synchronous to in_clk.

Decomposition:
- Package pb_pkg:
  - state typedef (IDLE, DELAY, REPEAT).
  - constants PB_RELEASED = 1'b1, PB_PRESSED = 1'b0.
  - default HOLD_CLKS / REPEAT_CLKS values.
  - REP_MAX = 8'd255.
- Sub-module pb_sync: 2-flop synchroniser with async active-low reset to 1; instantiated only under PB_EVENT_SYNC_EN.

Test Plan (HOLD_CLKS = 10, REPEAT_CLKS = 4, macro off unless stated):
- Reset with pb_level = 1, then deassert:
  - All outputs 0.
  - Drop pb_level at cycle 5 → press_pulse and move_pulse high at cycle 6 only; rep_cnt = 1.
- Hold 3 cycles, release:
  - release_pulse one cycle after rise.
  - No extra move_pulse; held never 1; rep_cnt stays 1.
- Hold 30 cycles from press:
  - move_pulse at press+1, press+11, then every 4 cycles (press+15, +19, +23, +27).
  - held = 1 from press+11.
  - rep_cnt = 6 at release.
- Release exactly on the cycle cnt reaches HOLD_CLKS-1: release_pulse only, no move_pulse, held stays 0.
- Hold ~1100 cycles: rep_cnt saturates at 255 and move_pulse keeps firing every 4 cycles.
- With PB_EVENT_SYNC_EN:
  - Press → press_pulse 3 cycles after edge.
  - Assert in_rst_n low mid-REPEAT → held/outputs 0 immediately.
  - After deassert with button held → new press_pulse.
